// File: rtl/rx_logic_if.sv
// Receive-side bundle between the link receivers, rx_logic and the router input fifo.
// The master modport belongs to the senders/fifo side; the slave modport belongs to rx_logic.
interface rx_logic_if #(
  parameter int SIZE       = 8,
  parameter int PORT_COUNT = 5
);
  logic [PORT_COUNT-1:0]      fifo_push_req;
  logic [PORT_COUNT-1:0]      fifo_push_ack;
  logic [PORT_COUNT*SIZE-1:0] fifo_push_data;
  logic                       fifo_write;
  logic [SIZE-1:0]            fifo_item_in;
  logic                       fifo_full;
  logic                       fifo_almost_full;

  modport master (
    output fifo_push_req, fifo_push_data, fifo_full, fifo_almost_full,
    input  fifo_push_ack, fifo_write, fifo_item_in
  );

  modport slave (
    input  fifo_push_req, fifo_push_data, fifo_full, fifo_almost_full,
    output fifo_push_ack, fifo_write, fifo_item_in
  );
endinterface

// File: rtl/rx_logic.sv
// Round-robin arbiter over PORT_COUNT 2-phase req/ack receivers, pushing at most
// one flit per cycle into the router input fifo while the fifo has room.
module rx_logic #(
  parameter int ID         = -1,
  parameter int SIZE       = 8,
  parameter int PORT_COUNT = 5
) (
  input  logic       clk,
  input  logic       reset,
  rx_logic_if.slave  rx
);

  localparam int IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [SIZE-1:0]       slice [PORT_COUNT];
  logic [PORT_COUNT-1:0] pend_p0;
  logic                  room_p0;
  logic                  grant_vld_p0;
  logic [IDX_W-1:0]      grant_p0;
  logic [IDX_W-1:0]      scan_p0;
  logic [SIZE-1:0]       sel_data_p0;
  logic [IDX_W-1:0]      last;
  int                    scan_idx;

  for (genvar k = 0; k < PORT_COUNT; k++) begin : g_slice
    assign slice[k] = rx.fifo_push_data[k*SIZE +: SIZE];
  end

  // Stage p0: pending detection, room check and round-robin scan from last+1
  always_comb begin
    pend_p0      = rx.fifo_push_req ^ rx.fifo_push_ack;
    // A write already presented with one slot left consumes that slot.
    room_p0      = ~rx.fifo_full & ~(rx.fifo_write & rx.fifo_almost_full);
    grant_vld_p0 = 1'b0;
    grant_p0     = '0;
    scan_p0      = '0;
    sel_data_p0  = '0;
    scan_idx     = 0;
    for (int i = 1; i <= PORT_COUNT; i++) begin
      scan_idx = int'(last) + i;
      if (scan_idx >= PORT_COUNT) scan_idx = scan_idx - PORT_COUNT;
      scan_p0 = IDX_W'(scan_idx);
      if (!grant_vld_p0 && pend_p0[scan_p0]) begin
        grant_vld_p0 = 1'b1;
        grant_p0     = scan_p0;
        sel_data_p0  = slice[scan_p0];
      end
    end
  end

  // Stage p1: registered fifo push, ack toggle and priority pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.fifo_push_ack <= '0;
      rx.fifo_write    <= 1'b0;
      rx.fifo_item_in  <= '0;
      last             <= IDX_W'(PORT_COUNT - 1);
    end else if (room_p0 && grant_vld_p0) begin
      assert (pend_p0[grant_p0])
        else $error("rx_logic %0d: grant to idle port %0d", ID, grant_p0);
      rx.fifo_item_in            <= sel_data_p0;
      rx.fifo_write              <= 1'b1;
      rx.fifo_push_ack[grant_p0] <= ~rx.fifo_push_ack[grant_p0];
      last                       <= grant_p0;
    end else begin
      rx.fifo_write <= 1'b0;
    end
  end

endmodule
